// File: rtl/cache_dm_wt_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_dm_wt_if
// Description : CPU-side and memory-side bus bundle for the direct-mapped
//               write-through cache. The slave modport is the cache's view.
//               The master modport is the CPU/memory environment's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_dm_wt_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // CPU side
  logic [ADDR_W-1:0] Adr;
  logic              Rd;
  logic              Wr;
  logic [DATA_W-1:0] D_i;
  logic              Flush;
  logic [DATA_W-1:0] D_o;
  logic              Ready;
  // Memory side
  logic [ADDR_W-1:0] Mem_Adr;
  logic              Mem_Rd;
  logic              Mem_Wr;
  logic [DATA_W-1:0] Mem_D_o;
  logic [DATA_W-1:0] Mem_D_i;
  logic              Mem_Ack;

  modport slave (
    input  Adr, Rd, Wr, D_i, Flush, Mem_D_i, Mem_Ack,
    output D_o, Ready, Mem_Adr, Mem_Rd, Mem_Wr, Mem_D_o
  );

  modport master (
    output Adr, Rd, Wr, D_i, Flush, Mem_D_i, Mem_Ack,
    input  D_o, Ready, Mem_Adr, Mem_Rd, Mem_Wr, Mem_D_o
  );
endinterface
`default_nettype wire

// File: rtl/cache_dm_wt.sv
`default_nettype none
// ============================================================================
// Module      : cache_dm_wt
// Description : Direct-mapped, write-through, no-write-allocate cache with one
//               word per line. Read hits complete in the same cycle. Read
//               misses refill from memory. All writes go through to memory.
//               Optional hit/miss counters are enabled by CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_dm_wt #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 6
) (
  input  wire          Clock_Puls,
  input  wire          Reset,
  cache_dm_wt_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]  Hit_Cnt,
  output logic [15:0]  Miss_Cnt
`endif
);

  localparam int c_LINES = 1 << INDEX_W;
  localparam int c_TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [DATA_W-1:0]   r_data [c_LINES];
  logic [c_TAG_W-1:0]  r_tag  [c_LINES];
  logic [c_LINES-1:0]  r_valid;
  logic [DATA_W-1:0]   r_fill_buf;

  logic [INDEX_W-1:0]  w_index;
  logic [c_TAG_W-1:0]  w_tag;
  logic                w_hit;
  logic                w_fill_we;
  logic                w_wr_upd;
  logic                w_flush;

  assign w_index = bus.Adr[INDEX_W-1:0];
  assign w_tag   = bus.Adr[ADDR_W-1:INDEX_W];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // State register; reset drops any memory transaction in flight.
  always_ff @(posedge Clock_Puls or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode plus all CPU-side and memory-side outputs.
  always_comb begin
    w_next      = r_state;
    bus.Ready   = 1'b0;
    bus.D_o     = '0;
    bus.Mem_Adr = '0;
    bus.Mem_Rd  = 1'b0;
    bus.Mem_Wr  = 1'b0;
    bus.Mem_D_o = '0;
    w_fill_we   = 1'b0;
    w_wr_upd    = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Write wins over read when both are requested.
        if (bus.Wr) begin
          w_next = S_WRITE;
        end else if (bus.Rd) begin
          if (w_hit) begin
            bus.Ready = 1'b1;
            bus.D_o   = r_data[w_index];
          end else begin
            w_next = S_FILL;
          end
        end else if (bus.Flush) begin
          w_flush = 1'b1;
        end
      end
      S_FILL: begin
        bus.Mem_Rd  = 1'b1;
        bus.Mem_Adr = bus.Adr;
        if (bus.Mem_Ack) begin
          w_fill_we = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_WRITE: begin
        bus.Mem_Wr  = 1'b1;
        bus.Mem_Adr = bus.Adr;
        bus.Mem_D_o = bus.D_i;
        if (bus.Mem_Ack) begin
          bus.Ready = 1'b1;
          // Keep the cached copy coherent only if the line is resident.
          w_wr_upd  = w_hit;
          w_next    = S_IDLE;
        end
      end
      S_RESP: begin
        bus.Ready = 1'b1;
        bus.D_o   = r_fill_buf;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Valid bits and the refill word buffer are the only reset cache state.
  always_ff @(posedge Clock_Puls or negedge Reset) begin
    if (!Reset) begin
      r_valid    <= '0;
      r_fill_buf <= '0;
    end else begin
      if (w_flush) begin
        r_valid <= '0;
      end else if (w_fill_we) begin
        r_valid[w_index] <= 1'b1;
      end
      if (w_fill_we) r_fill_buf <= bus.Mem_D_i;
    end
  end

  // Data and tag storage; never cleared, validity is tracked by r_valid.
  always_ff @(posedge Clock_Puls) begin
    if (w_fill_we) begin
      r_data[w_index] <= bus.Mem_D_i;
      r_tag[w_index]  <= w_tag;
    end else if (w_wr_upd) begin
      r_data[w_index] <= bus.D_i;
    end
  end

`ifdef CACHE_STATS_EN
  logic w_rd_req;
  logic w_rd_hit;
  logic w_rd_miss;

  assign w_rd_req  = (r_state == S_IDLE) && bus.Rd && !bus.Wr;
  assign w_rd_hit  = w_rd_req && w_hit;
  assign w_rd_miss = w_rd_req && !w_hit;

  // Saturating hit/miss counters; a miss is counted on the way into FILL.
  always_ff @(posedge Clock_Puls or negedge Reset) begin
    if (!Reset) begin
      Hit_Cnt  <= '0;
      Miss_Cnt <= '0;
    end else begin
      if (w_rd_hit && (Hit_Cnt != 16'hFFFF))   Hit_Cnt  <= Hit_Cnt + 16'd1;
      if (w_rd_miss && (Miss_Cnt != 16'hFFFF)) Miss_Cnt <= Miss_Cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_dm_wt.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_dm_wt
// Description : Scoreboard bench for cache_dm_wt. A driver issues CPU
//               requests and pushes the expected response. A memory
//               responder answers with variable latency. A monitor pops
//               and compares whenever Ready is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_dm_wt;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int INDEX_W = 6;
  localparam int LINES   = 1 << INDEX_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_dm_wt_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  cache_dm_wt #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W)
  ) dut (
    .Clock_Puls(clk),
    .Reset     (rst_n),
    .bus       (bus)
`ifdef CACHE_STATS_EN
    ,
    .Hit_Cnt   (hit_cnt),
    .Miss_Cnt  (miss_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    bit          miss;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [int];   // what memory must hold (from CPU writes)
  logic [15:0] phys_mem[int];   // what the memory device actually holds
  int          m_line  [int];   // line index -> address currently cached
  int          m_hits   = 0;
  int          m_misses = 0;

  function automatic logic [15:0] mem_init(input int a);
    return 16'((a * 977) + 499);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [15:0] phys_rd(input int a);
    return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
  endfunction

  // ---------------- memory responder ----------------
  bit mem_auto    = 1'b1;
  bit mem_rand    = 1'b0;
  int mem_lat     = 3;
  bit inject_ack  = 1'b0;
  bit inject_done = 1'b0;

  initial begin
    int lat;
    bus.Mem_Ack = 1'b0;
    bus.Mem_D_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (inject_ack && !inject_done) begin
        bus.Mem_D_i = 16'hDEAD;
        bus.Mem_Ack = 1'b1;
        @(posedge clk);
        #2;
        bus.Mem_Ack = 1'b0;
        bus.Mem_D_i = '0;
        inject_done = 1'b1;
      end else if (mem_auto && rst_n && (bus.Mem_Rd || bus.Mem_Wr)) begin
        lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk);
          #2;
        end
        if (bus.Mem_Rd) bus.Mem_D_i = phys_rd(int'(bus.Mem_Adr));
        else            phys_mem[int'(bus.Mem_Adr)] = bus.Mem_D_o;
        bus.Mem_Ack = 1'b1;
        @(posedge clk);
        #2;
        bus.Mem_Ack = 1'b0;
        bus.Mem_D_i = '0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit   seen_rd = 1'b0;
  bit   seen_wr = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen_rd = 1'b0;
      seen_wr = 1'b0;
    end else begin
      if (bus.Mem_Rd) seen_rd = 1'b1;
      if (bus.Mem_Wr) seen_wr = 1'b1;
      if (bus.Mem_Rd || bus.Mem_Wr) begin
        check("mem_rd_wr_excl", {31'd0, bus.Mem_Rd & bus.Mem_Wr}, 32'd0);
        check("mem_adr", {16'd0, bus.Mem_Adr}, {16'd0, bus.Adr});
      end
      if (bus.Mem_Wr) check("mem_wdata", {16'd0, bus.Mem_D_o}, {16'd0, bus.D_i});
      if (bus.Ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got=1 want=0 @%0t", $time);
        end else begin
          mon_e = sb.pop_front();
          check(mon_e.is_rd ? "rd_data" : "wr_d_o", {16'd0, bus.D_o}, {16'd0, mon_e.data});
          check(mon_e.is_rd ? "rd_mem_fetch" : "wr_no_fetch", {31'd0, seen_rd}, {31'd0, mon_e.miss});
          check("mem_write_issued", {31'd0, seen_wr}, {31'd0, !mon_e.is_rd});
        end
        seen_rd = 1'b0;
        seen_wr = 1'b0;
      end else if (!bus.Rd && !bus.Wr) begin
        check("idle_d_o", {16'd0, bus.D_o}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input bit flush_during);
    exp_t e;
    int   idx;
    bit   done;
    idx = int'(a) % LINES;
    if (wr) begin
      e.is_rd = 1'b0;
      e.data  = '0;
      e.miss  = 1'b0;
      ref_mem[int'(a)] = d;
    end else begin
      e.is_rd = 1'b1;
      e.data  = ref_rd(int'(a));
      e.miss  = !(m_line.exists(idx) && (m_line[idx] == int'(a)));
      if (e.miss) begin
        m_line[idx] = int'(a);
        m_misses++;
      end else begin
        m_hits++;
      end
    end
    sb.push_back(e);
    bus.Adr   = a;
    bus.Rd    = !wr;
    bus.Wr    = wr;
    bus.D_i   = wr ? d : 16'h0;
    bus.Flush = flush_during;
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.Ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got=no_ready want=ready adr=%0h @%0t", a, $time);
      sb.delete();
    end
    @(posedge clk);
    #1;
    bus.Rd    = 1'b0;
    bus.Wr    = 1'b0;
    bus.Flush = 1'b0;
  endtask

  task automatic do_flush();
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    m_line.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int r;
    logic [15:0] a;
    bus.Adr   = '0;
    bus.Rd    = 1'b0;
    bus.Wr    = 1'b0;
    bus.D_i   = '0;
    bus.Flush = 1'b0;
    #3;
    check("rst_ready",   {31'd0, bus.Ready},   32'd0);
    check("rst_d_o",     {16'd0, bus.D_o},     32'd0);
    check("rst_mem_rd",  {31'd0, bus.Mem_Rd},  32'd0);
    check("rst_mem_wr",  {31'd0, bus.Mem_Wr},  32'd0);
    check("rst_mem_adr", {16'd0, bus.Mem_Adr}, 32'd0);
    check("rst_mem_d_o", {16'd0, bus.Mem_D_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed sequence with fixed memory latency of 3.
    ref_mem[16'h0041]  = 16'hBEEF;  phys_mem[16'h0041] = 16'hBEEF;
    ref_mem[16'h0081]  = 16'h5555;  phys_mem[16'h0081] = 16'h5555;
    @(posedge clk);
    #1;
    do_req(1'b0, 16'h0041, 16'h0, 1'b0);   // miss, refill BEEF
    do_req(1'b0, 16'h0041, 16'h0, 1'b0);   // hit
`ifdef CACHE_STATS_EN
    check("stats_hit_1",  {16'd0, hit_cnt},  32'd1);
    check("stats_miss_1", {16'd0, miss_cnt}, 32'd1);
`endif
    do_req(1'b1, 16'h0041, 16'h1234, 1'b0); // write hit
    do_req(1'b0, 16'h0041, 16'h0, 1'b0);   // hit with new data
    do_req(1'b0, 16'h0081, 16'h0, 1'b0);   // conflict miss
    do_req(1'b0, 16'h0041, 16'h0, 1'b0);   // miss again, write-through data
    do_flush();
    do_req(1'b0, 16'h0081, 16'h0, 1'b0);   // miss after flush
    do_req(1'b0, 16'h0041, 16'h0, 1'b1);   // flush held through FILL: ignored
    do_req(1'b0, 16'h0041, 16'h0, 1'b0);   // still a hit
    do_req(1'b1, 16'h00C1, 16'hA5A5, 1'b0); // write miss: no allocate
    do_req(1'b0, 16'h00C1, 16'h0, 1'b0);   // miss, refilled from memory

    // Reset asserted in the middle of a refill.
    mem_auto = 1'b0;
    bus.Adr  = 16'h00C5;
    bus.Rd   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_mem_rd_pre", {31'd0, bus.Mem_Rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_rd",  {31'd0, bus.Mem_Rd},  32'd0);
    check("abort_ready",   {31'd0, bus.Ready},   32'd0);
    check("abort_mem_adr", {16'd0, bus.Mem_Adr}, 32'd0);
    m_line.delete();
    m_hits   = 0;
    m_misses = 0;
    bus.Rd   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    inject_ack = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (inject_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL inject_timeout: got=no_ack want=ack @%0t", $time);
    end
    inject_ack = 1'b0;
    mem_auto   = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 16'h00C5, 16'h0, 1'b0);   // stray ack had no effect: miss

    // Randomized traffic over a few tags and indices.
    mem_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      a = 16'(($urandom_range(0, 3) << INDEX_W) | $urandom_range(0, 7));
      if (r < 50)      do_req(1'b0, a, 16'h0, 1'b0);
      else if (r < 85) do_req(1'b1, a, 16'($urandom()), 1'b0);
      else             do_flush();
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef CACHE_STATS_EN
    check("stats_hit_end",  {16'd0, hit_cnt},  32'(m_hits));
    check("stats_miss_end", {16'd0, miss_cnt}, 32'(m_misses));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
